// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words,
// writes them to instruction memory from BASE_ADDR upward, and holds the core
// in reset until the requested number of words has been written.
module instr_mem_loader #(
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DEPTH_WORDS   = 1024,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int unsigned              CNT_WIDTH     = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_Start,
  input  logic [CNT_WIDTH-1:0]     i_NumWords,
  input  logic                     i_ByteValid,
  input  logic [7:0]               i_ByteData,
  output logic                     o_ByteReady,
  output logic                     o_IMemWE,
  output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
  output logic [DATA_WIDTH-1:0]    o_IMemWData,
  output logic                     o_CoreHold,
  output logic                     o_Done,
  output logic                     o_Error,
  output logic [CNT_WIDTH-1:0]     o_WordCount
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } stateT;

  // Depth limit widened by one bit so DEPTH_WORDS itself fits even when it
  // equals 2**CNT_WIDTH.
  localparam logic [CNT_WIDTH:0] DEPTH_LIMIT = (CNT_WIDTH + 1)'(DEPTH_WORDS);

  stateT                    state;
  stateT                    nextState;

  logic [CNT_WIDTH-1:0]     numWordsQ;
  logic [CNT_WIDTH-1:0]     wordCount;
  logic [CNT_WIDTH-1:0]     wordCountNext;
  logic [1:0]               byteCnt;
  logic [DATA_WIDTH-1:0]    asmWord;
  logic [ADDRESS_WIDTH-1:0] imemAddr;
  logic [DATA_WIDTH-1:0]    imemWData;
  logic                     coreHold;
  logic                     doneFlag;
  logic                     errorFlag;

  logic                     byteReady;
  logic                     imemWe;
  logic                     byteXfer;
  logic                     lastByte;
  logic                     lastWord;
  logic                     idleLike;
  logic                     startOk;
  logic                     startAccept;
  logic [ADDRESS_WIDTH-1:0] addrOffset;

  assign byteXfer      = i_ByteValid && byteReady;
  assign lastByte      = (byteCnt == 2'd3);
  assign wordCountNext = wordCount + CNT_WIDTH'(1);
  assign lastWord      = (wordCountNext == numWordsQ);
  assign idleLike      = (state inside {IDLE, DONE, ERR});
  assign startOk       = (i_NumWords != '0) && ({1'b0, i_NumWords} <= DEPTH_LIMIT);
  assign startAccept   = idleLike && i_Start && startOk;
  assign addrOffset    = ADDRESS_WIDTH'({wordCount, 2'b00});

  // State register
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; i_Start only matters outside an active load
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (i_Start) begin
          nextState = startOk ? RECV : ERR;
        end
      end
      RECV: begin
        if (byteXfer && lastByte) begin
          nextState = WRITE;
        end
      end
      WRITE: begin
        nextState = lastWord ? DONE : RECV;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Output decode of the current state
  always_comb begin
    byteReady = 1'b0;
    imemWe    = 1'b0;
    unique case (state)
      RECV:    byteReady = 1'b1;
      WRITE:   imemWe    = 1'b1;
      default: begin
        byteReady = 1'b0;
        imemWe    = 1'b0;
      end
    endcase
  end

  // Status flags registered from the next state so CoreHold never glitches
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      coreHold  <= 1'b1;
      doneFlag  <= 1'b0;
      errorFlag <= 1'b0;
    end else begin
      coreHold  <= (nextState != DONE);
      doneFlag  <= (nextState == DONE);
      errorFlag <= (nextState == ERR);
    end
  end

  // Word assembly, write address/data capture and word counting
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      numWordsQ <= '0;
      wordCount <= '0;
      byteCnt   <= '0;
      asmWord   <= '0;
      imemAddr  <= '0;
      imemWData <= '0;
    end else begin
      if (startAccept) begin
        numWordsQ <= i_NumWords;
        wordCount <= '0;
        byteCnt   <= '0;
      end
      if (byteXfer) begin
        asmWord <= {asmWord[DATA_WIDTH-9:0], i_ByteData};
        byteCnt <= byteCnt + 2'd1;
        // Write data/address are captured alongside the 4th byte so they
        // stay stable outside the write pulse while the next word assembles.
        if (lastByte) begin
          imemWData <= {asmWord[DATA_WIDTH-9:0], i_ByteData};
          imemAddr  <= BASE_ADDR + addrOffset;
        end
      end
      if (imemWe) begin
        wordCount <= wordCountNext;
      end
    end
  end

  assign o_ByteReady = byteReady;
  assign o_IMemWE    = imemWe;
  assign o_IMemAddr  = imemAddr;
  assign o_IMemWData = imemWData;
  assign o_CoreHold  = coreHold;
  assign o_Done      = doneFlag;
  assign o_Error     = errorFlag;
  assign o_WordCount = wordCount;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: randomized byte streams checked
// every cycle against a transaction-level model, plus literal expectations.
module tb_instr_mem_loader;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk       = 1'b0;
  logic        rstN      = 1'b0;
  logic        start     = 1'b0;
  logic [15:0] numWords  = '0;
  logic        byteValid = 1'b0;
  logic [7:0]  byteData  = '0;

  logic        o_ByteReady;
  logic        o_IMemWE;
  logic [31:0] o_IMemAddr;
  logic [31:0] o_IMemWData;
  logic        o_CoreHold;
  logic        o_Done;
  logic        o_Error;
  logic [15:0] o_WordCount;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(32),
    .DEPTH_WORDS  (DEPTH),
    .BASE_ADDR    (BASE),
    .CNT_WIDTH    (16)
  ) dut (
    .i_CLK      (clk),
    .i_RST      (rstN),
    .i_Start    (start),
    .i_NumWords (numWords),
    .i_ByteValid(byteValid),
    .i_ByteData (byteData),
    .o_ByteReady(o_ByteReady),
    .o_IMemWE   (o_IMemWE),
    .o_IMemAddr (o_IMemAddr),
    .o_IMemWData(o_IMemWData),
    .o_CoreHold (o_CoreHold),
    .o_Done     (o_Done),
    .o_Error    (o_Error),
    .o_WordCount(o_WordCount)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // Writes observed on the memory port: {addr, data}
  logic [63:0] wrLog[$];

  // Transaction-level model: load in progress, pending write, bytes so far
  bit          mLoading;
  bit          mWePending;
  bit          mDone;
  bit          mError;
  int          mBytes;
  int          mWords;
  int          mNum;
  logic [31:0] mAsm;
  logic [31:0] mAddr;
  logic [31:0] mData;

  // Compare process: check outputs at the falling edge, then advance the
  // model with the inputs that the next rising edge will see.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstN) begin
        mLoading = 0; mWePending = 0; mDone = 0; mError = 0;
        mBytes = 0; mWords = 0; mNum = 0;
        mAsm = '0; mAddr = '0; mData = '0;
      end
      chk("ByteReady", o_ByteReady, mLoading && !mWePending);
      chk("IMemWE",    o_IMemWE,    mWePending);
      chk("IMemAddr",  o_IMemAddr,  mAddr);
      chk("IMemWData", o_IMemWData, mData);
      chk("CoreHold",  o_CoreHold,  !mDone);
      chk("Done",      o_Done,      mDone);
      chk("Error",     o_Error,     mError);
      chk("WordCount", o_WordCount, 16'(mWords));
      if (o_IMemWE) wrLog.push_back({o_IMemAddr, o_IMemWData});
      if (rstN) begin
        if (mWePending) begin
          mWePending = 0;
          mWords++;
          if (mWords == mNum) begin
            mLoading = 0;
            mDone    = 1;
          end
        end else if (mLoading) begin
          if (byteValid) begin
            mAsm = {mAsm[23:0], byteData};
            mBytes++;
            if (mBytes == 4) begin
              mBytes     = 0;
              mWePending = 1;
              mAddr      = BASE + 32'(4 * mWords);
              mData      = mAsm;
            end
          end
        end else if (start) begin
          if (numWords == 0 || numWords > DEPTH) begin
            mError = 1;
            mDone  = 0;
          end else begin
            mLoading = 1; mNum = int'(numWords); mWords = 0; mBytes = 0;
            mDone = 0; mError = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input int n);
    start    = 1'b1;
    numWords = 16'(n);
    step();
    start    = 1'b0;
    numWords = 16'($urandom);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int  tries = 0;
    bit  sent  = 0;
    while (!sent) begin
      byteValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      byteData  = byteValid ? b : 8'($urandom);
      sent      = byteValid && o_ByteReady;
      step();
      tries++;
      if (!sent && tries > 50) begin
        timeoutFail("ByteAccept");
        sent = 1;
      end
    end
    byteValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gaps);
    sendByte(w[31:24], gaps);
    sendByte(w[23:16], gaps);
    sendByte(w[15:8],  gaps);
    sendByte(w[7:0],   gaps);
  endtask

  task automatic waitFlag(input int budget);
    int n = 0;
    while (!o_Done && !o_Error && n < budget) begin
      step();
      n++;
    end
    if (!o_Done && !o_Error) timeoutFail("WaitDone");
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, "_Ready"}, o_ByteReady, 1'b0);
    chk({tag, "_WE"},    o_IMemWE,    1'b0);
    chk({tag, "_Addr"},  o_IMemAddr,  32'h0);
    chk({tag, "_WData"}, o_IMemWData, 32'h0);
    chk({tag, "_Hold"},  o_CoreHold,  1'b1);
    chk({tag, "_Done"},  o_Done,      1'b0);
    chk({tag, "_Error"}, o_Error,     1'b0);
    chk({tag, "_Count"}, o_WordCount, 16'h0);
  endtask

  task automatic t1Load(input bit gaps, input string tag);
    wrLog.delete();
    pulseStart(2);
    sendWord(32'h20080005, gaps);
    sendWord(32'h00000000, gaps);
    waitFlag(20);
    chk({tag, "_NumWr"}, 64'(wrLog.size()), 64'd2);
    chk({tag, "_Wr0"},   wrLog[0], {32'h0, 32'h20080005});
    chk({tag, "_Wr1"},   wrLog[1], {32'h4, 32'h00000000});
    chk({tag, "_Done"},  o_Done, 1'b1);
    chk({tag, "_Hold"},  o_CoreHold, 1'b0);
    chk({tag, "_Count"}, o_WordCount, 16'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL Watchdog global time limit t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    checkResetValues("Reset");
    step();
    rstN = 1'b1;
    step();

    // Basic load, then the same with random valid gaps
    t1Load(1'b0, "T1");
    t1Load(1'b1, "T2");

    // Rejected requests, then an accepted one
    wrLog.delete();
    pulseStart(0);
    step();
    chk("T3_Zero_Error", o_Error, 1'b1);
    chk("T3_Zero_Hold",  o_CoreHold, 1'b1);
    pulseStart(DEPTH + 1);
    step();
    chk("T3_Big_Error",  o_Error, 1'b1);
    chk("T3_Big_Hold",   o_CoreHold, 1'b1);
    chk("T3_NoWrites",   64'(wrLog.size()), 64'd0);
    pulseStart(1);
    chk("T3_ErrorClear", o_Error, 1'b0);
    sendWord(32'hDEADBEEF, 1'b1);
    waitFlag(20);
    chk("T3_Wr0",  wrLog[0], {32'h0, 32'hDEADBEEF});
    chk("T3_Done", o_Done, 1'b1);

    // Reset mid-word, then a clean single-word load
    pulseStart(3);
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    rstN = 1'b0;
    #1;
    checkResetValues("T4");
    step();
    rstN = 1'b1;
    step();
    wrLog.delete();
    pulseStart(1);
    sendWord(32'hAABBCCDD, 1'b0);
    waitFlag(20);
    chk("T4_NumWr", 64'(wrLog.size()), 64'd1);
    chk("T4_Wr0",   wrLog[0], {32'h0, 32'hAABBCCDD});

    // Start during RECV is ignored; start in DONE reloads from BASE
    wrLog.delete();
    pulseStart(2);
    sendByte(8'h20, 1'b0);
    sendByte(8'h08, 1'b0);
    pulseStart(7);
    sendByte(8'h00, 1'b0);
    sendByte(8'h05, 1'b0);
    sendWord(32'h0, 1'b0);
    waitFlag(20);
    chk("T5_NumWr", 64'(wrLog.size()), 64'd2);
    chk("T5_Wr0",   wrLog[0], {32'h0, 32'h20080005});
    chk("T5_Wr1",   wrLog[1], {32'h4, 32'h00000000});
    chk("T5_Count", o_WordCount, 16'd2);
    pulseStart(1);
    chk("T5_HoldAgain", o_CoreHold, 1'b1);
    chk("T5_DoneClear", o_Done, 1'b0);
    sendWord(32'h12345678, 1'b1);
    waitFlag(20);
    chk("T5_Rewrite", wrLog[wrLog.size()-1], {32'h0, 32'h12345678});

    // Random loads and rejects, all checked by the model
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(0, 7);
      if (n == 7) n = DEPTH + 1 + $urandom_range(0, 100);
      pulseStart(n);
      if (n == 0 || n > DEPTH) begin
        step();
        chk("Rand_Reject", o_Error, 1'b1);
      end else begin
        for (int w = 0; w < n; w++) sendWord($urandom, 1'b1);
        waitFlag(20);
        chk("Rand_Count", o_WordCount, 16'(n));
      end
    end

    // Full-depth load
    wrLog.delete();
    pulseStart(DEPTH);
    for (int w = 0; w < DEPTH; w++) sendWord($urandom, 1'b0);
    waitFlag(20);
    chk("T6_NumWr",  64'(wrLog.size()), 64'(DEPTH));
    chk("T6_LastAd", 64'(wrLog[wrLog.size()-1][63:32]), 64'h0FFC);
    chk("T6_Done",   o_Done, 1'b1);
    chk("T6_Count",  o_WordCount, 16'd1024);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
